cmd_frame_decoder: RTL

Byte-level command decoder sitting directly downstream of the UART-RX data synchronizer in the system clock domain. It consumes one synchronized byte per enable pulse, parses four fixed command frames, and drives single-cycle register-file write/read strobes and ALU start strobes. It also drives the ALU clock-gate enable so the ALU clock runs only while an ALU command is in flight. Read data and ALU results are returned by a separate TX controller, which is out of scope here.

---
 rtl/cmd_frame_pkg.sv | 23 ++
 rtl/frame_timeout_counter.sv | 36 +++
 rtl/cmd_frame_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared constants for the UART command-frame decoder: command codes,
// FSM state encoding and the fixed ALU operand register addresses.
package cmd_frame_pkg;

  localparam logic [7:0] CMD_RF_WR     = 8'hAA;
  localparam logic [7:0] CMD_RF_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPS   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOOPS = 8'hDD;

  localparam int unsigned OPERAND_A_ADDR = 0;
  localparam int unsigned OPERAND_B_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_OP_A    = 3'd4,
    ST_OP_B    = 3'd5,
    ST_ALU_FUN = 3'd6
  } state_t;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: reloads on every accepted in-frame byte, counts down
// to zero and flags expiry; frozen while the decoder is idle.
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic hold,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

  logic [CW-1:0] count_r;

  // Down-counter; saturates at zero so expiry stays visible until reload.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= RELOAD;
    end else if (hold) begin
      count_r <= count_r;
    end else if (count_r != ZERO) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == ZERO);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-stream command decoder: parses RF write/read and ALU frames and issues
// registered single-cycle register-file and ALU strobes.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  BUSY,
  output logic                  FRAME_ERR
);

  localparam logic [DATA_WIDTH-1:0] CODE_WR     = DATA_WIDTH'(CMD_RF_WR);
  localparam logic [DATA_WIDTH-1:0] CODE_RD     = DATA_WIDTH'(CMD_RF_RD);
  localparam logic [DATA_WIDTH-1:0] CODE_OPS    = DATA_WIDTH'(CMD_ALU_OPS);
  localparam logic [DATA_WIDTH-1:0] CODE_NOOPS  = DATA_WIDTH'(CMD_ALU_NOOPS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A   = ADDR_WIDTH'(OPERAND_A_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B   = ADDR_WIDTH'(OPERAND_B_ADDR);

  state_t state_r;
  state_t state_next;
  logic   bad_cmd_s;
  logic   timeout_s;
  logic   expired_s;
  logic   load_s;
  logic   hold_s;
  logic   alu_start_s;

  // Next-state decode; an arriving byte always takes priority over expiry.
  always_comb begin
    state_next = state_r;
    bad_cmd_s  = 1'b0;
    timeout_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      if (RX_D_VLD) begin
        case (RX_P_DATA)
          CODE_WR:    state_next = ST_WR_ADDR;
          CODE_RD:    state_next = ST_RD_ADDR;
          CODE_OPS:   state_next = ST_OP_A;
          CODE_NOOPS: state_next = ST_ALU_FUN;
          default:    bad_cmd_s  = 1'b1;
        endcase
      end else begin
        state_next = ST_IDLE;
      end
    end else if (RX_D_VLD) begin
      case (state_r)
        ST_WR_ADDR: state_next = ST_WR_DATA;
        ST_OP_A:    state_next = ST_OP_B;
        ST_OP_B:    state_next = ST_ALU_FUN;
        // WR_DATA, RD_ADDR and ALU_FUN consume the frame's last byte.
        default:    state_next = ST_IDLE;
      endcase
    end else if (expired_s) begin
      state_next = ST_IDLE;
      timeout_s  = 1'b1;
    end else begin
      state_next = state_r;
    end
  end

  assign load_s      = RX_D_VLD && (state_next != ST_IDLE);
  assign hold_s      = (state_r == ST_IDLE) && !load_s;
  assign alu_start_s = RX_D_VLD && (state_r == ST_ALU_FUN);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load_s),
    .hold    (hold_s),
    .expired (expired_s)
  );

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      RF_ADDR     <= {ADDR_WIDTH{1'b0}};
      RF_WR_DATA  <= {DATA_WIDTH{1'b0}};
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_FUN     <= {FUN_WIDTH{1'b0}};
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      state_r   <= state_next;
      RF_WR_EN  <= 1'b0;
      RF_RD_EN  <= 1'b0;
      ALU_EN    <= 1'b0;
      FRAME_ERR <= bad_cmd_s | timeout_s;
      BUSY      <= (state_next != ST_IDLE);
      // Gate stays open while in ALU_FUN, during ALU_EN and one cycle after.
      CLK_GATE_EN <= (state_next == ST_ALU_FUN) | alu_start_s | ALU_EN;
      if (RX_D_VLD) begin
        case (state_r)
          ST_WR_ADDR: RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
          ST_WR_DATA: begin
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
          end
          ST_RD_ADDR: begin
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
          end
          ST_OP_A: begin
            RF_ADDR    <= ADDR_OP_A;
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
          end
          ST_OP_B: begin
            RF_ADDR    <= ADDR_OP_B;
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
          end
          ST_ALU_FUN: begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
          end
          default: RF_WR_EN <= 1'b0;
        endcase
      end
    end
  end

endmodule
